// File: rtl/perceptron_bp_table.sv
// -----------------------------------------------------------------------------
// perceptron_bp_table
//
// Global-history perceptron branch predictor. The design holds a table of
// perceptron rows, indexed by PC bits, and a speculative global history
// register (GHR).
//
// Prediction is combinational from pred_pc. Training is accepted from EX
// branch resolution and runs as a three-cycle IDLE -> CALC -> WRITE sequence.
// A mispredicting update restores the GHR from the snapshot that was carried
// down the pipe.
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   pred_valid        IF has a branch this cycle; its prediction enters the GHR
//   pred_pc           PC being predicted
//   pred_taken        predicted direction (0 until the init sweep is done)
//   pred_conf         signed perceptron sum (0 until the init sweep is done)
//   pred_ghr          GHR value used for this prediction
//   init_done         table sweep complete
//   upd_valid/ready   resolved-branch handshake (accepted when both are high)
//   upd_pc            PC of the resolved branch
//   upd_ghr           pred_ghr snapshot taken at prediction time
//   upd_taken         actual outcome
//   upd_mispredict    restore the GHR from upd_ghr/upd_taken on acceptance
// -----------------------------------------------------------------------------
module perceptron_bp_table #(
   parameter int PC_W        = 32,
   parameter int TABLE_DEPTH = 16,
   parameter int HIST_LEN    = 8,
   parameter int WEIGHT_W    = 8,
   parameter int THETA       = 29,
   localparam int IDX_W      = $clog2(TABLE_DEPTH),
   localparam int SUM_W      = WEIGHT_W + $clog2(HIST_LEN + 1) + 1
) (
   input  logic                clk,
   input  logic                rst_n,
   // prediction side (IF)
   input  logic                pred_valid,
   input  logic [PC_W-1:0]     pred_pc,
   output logic                pred_taken,
   output logic [SUM_W-1:0]    pred_conf,
   output logic [HIST_LEN-1:0] pred_ghr,
   output logic                init_done,
   // update side (EX)
   input  logic                upd_valid,
   output logic                upd_ready,
   input  logic [PC_W-1:0]     upd_pc,
   input  logic [HIST_LEN-1:0] upd_ghr,
   input  logic                upd_taken,
   input  logic                upd_mispredict
);

   // Each row packs the bias w0 in the lowest slice, then w1..wHIST_LEN.
   localparam int ROW_W = (HIST_LEN + 1) * WEIGHT_W;

   localparam logic signed [WEIGHT_W-1:0] W_POS = WEIGHT_W'((2 ** (WEIGHT_W - 1)) - 1);
   localparam logic signed [WEIGHT_W-1:0] W_NEG = -W_POS;
   localparam logic signed [WEIGHT_W-1:0] W_ONE = WEIGHT_W'(1);

   typedef enum logic [1:0] {
      ST_INIT,
      ST_IDLE,
      ST_CALC,
      ST_WRITE
   } state_t;

   // --------------------------------------------------------------------------
   // Helpers
   // --------------------------------------------------------------------------
   function automatic logic signed [SUM_W-1:0] sext_w(input logic [WEIGHT_W-1:0] w);
      return $signed({{(SUM_W - WEIGHT_W){w[WEIGHT_W-1]}}, w});
   endfunction

   // The bias is always added. Each history weight is added when its history
   // bit is 1 (x = +1) and subtracted when it is 0 (x = -1). SUM_W is wide
   // enough that this can never overflow.
   function automatic logic signed [SUM_W-1:0] row_sum(input logic [ROW_W-1:0]    row,
                                                       input logic [HIST_LEN-1:0] hist);
      logic signed [SUM_W-1:0] acc;
      logic signed [SUM_W-1:0] term;
      acc = sext_w(row[WEIGHT_W-1:0]);
      for (int i = 1; i <= HIST_LEN; i++) begin
         term = sext_w(row[i*WEIGHT_W +: WEIGHT_W]);
         acc  = hist[i-1] ? (acc + term) : (acc - term);
      end
      return acc;
   endfunction

   // --------------------------------------------------------------------------
   // State
   // --------------------------------------------------------------------------
   logic [ROW_W-1:0]    table_mem [TABLE_DEPTH];

   state_t              state_reg;
   logic [IDX_W-1:0]    init_cnt_reg;
   logic                init_done_reg;
   logic                upd_ready_reg;
   logic [HIST_LEN-1:0] ghr_reg;

   // Values latched at acceptance, plus the row and decision latched in CALC.
   logic [IDX_W-1:0]    idx_reg;
   logic [HIST_LEN-1:0] ghr_lat_reg;
   logic                taken_reg;
   logic [ROW_W-1:0]    row_reg;
   logic                train_reg;

   // --------------------------------------------------------------------------
   // Prediction path (combinational)
   // --------------------------------------------------------------------------
   logic [IDX_W-1:0]        pred_idx;
   logic signed [SUM_W-1:0] pred_sum;

   assign pred_idx = pred_pc[IDX_W+1:2];
   assign pred_sum = row_sum(table_mem[pred_idx], ghr_reg);

   // Table contents are undefined during the sweep, so both outputs are
   // forced to zero until the sweep finishes.
   assign pred_taken = init_done_reg & ~pred_sum[SUM_W-1];
   assign pred_conf  = init_done_reg ? pred_sum : '0;
   assign pred_ghr   = ghr_reg;
   assign init_done  = init_done_reg;
   assign upd_ready  = upd_ready_reg;

   // PC bits outside the index field do not take part in indexing.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{pred_pc[PC_W-1:IDX_W+2], pred_pc[1:0],
                             upd_pc[PC_W-1:IDX_W+2],  upd_pc[1:0]};

   // --------------------------------------------------------------------------
   // Training decision (evaluated in CALC from the latched history)
   // --------------------------------------------------------------------------
   logic signed [SUM_W-1:0] calc_sum;
   logic signed [31:0]      calc_sum_ext;
   logic                    calc_small;
   logic                    calc_wrong;
   logic                    calc_train;

   assign calc_sum     = row_sum(table_mem[idx_reg], ghr_lat_reg);
   // THETA may exceed the range of SUM_W, so the magnitude test is done at
   // 32 bits.
   assign calc_sum_ext = $signed({{(32 - SUM_W){calc_sum[SUM_W-1]}}, calc_sum});
   assign calc_small   = (calc_sum_ext <= THETA) && (calc_sum_ext >= -THETA);
   assign calc_wrong   = (~calc_sum[SUM_W-1]) != taken_reg;
   assign calc_train   = calc_wrong | calc_small;

   // --------------------------------------------------------------------------
   // Weight update: one saturating +/-1 step per weight.
   // t = +1 for taken and -1 for not taken.
   // w0 moves by t, and w_i moves by t*x_i, so w_i increments exactly when
   // its history bit agrees with the outcome.
   // --------------------------------------------------------------------------
   logic [ROW_W-1:0] trained_row;

   genvar gi;
   generate
      for (gi = 0; gi <= HIST_LEN; gi++) begin : g_train
         logic signed [WEIGHT_W-1:0] w_old;
         logic                       inc;

         assign w_old = row_reg[gi*WEIGHT_W +: WEIGHT_W];

         if (gi == 0) begin : g_bias
            assign inc = taken_reg;
         end else begin : g_hist
            assign inc = (ghr_lat_reg[gi-1] == taken_reg);
         end

         // The symmetric clamp keeps -2^(WEIGHT_W-1) out of the table.
         assign trained_row[gi*WEIGHT_W +: WEIGHT_W] =
            inc ? ((w_old == W_POS) ? w_old : (w_old + W_ONE))
                : ((w_old == W_NEG) ? w_old : (w_old - W_ONE));
      end
   endgenerate

   // --------------------------------------------------------------------------
   // Table write port. It is written by the INIT sweep, or when leaving WRITE
   // if the row trains. An async reset forces the state to INIT, so a write
   // still pending in CALC/WRITE never lands.
   // --------------------------------------------------------------------------
   logic             tbl_we;
   logic [IDX_W-1:0] tbl_waddr;
   logic [ROW_W-1:0] tbl_wdata;

   assign tbl_we    = (state_reg == ST_INIT) || ((state_reg == ST_WRITE) && train_reg);
   assign tbl_waddr = (state_reg == ST_INIT) ? init_cnt_reg : idx_reg;
   assign tbl_wdata = (state_reg == ST_INIT) ? '0 : trained_row;

   always_ff @(posedge clk) begin
      if (tbl_we) begin
         table_mem[tbl_waddr] <= tbl_wdata;
      end
   end

   // --------------------------------------------------------------------------
   // Update FSM
   // --------------------------------------------------------------------------
   logic upd_accept;
   assign upd_accept = upd_valid & upd_ready_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg     <= ST_INIT;
         init_cnt_reg  <= '0;
         init_done_reg <= 1'b0;
         upd_ready_reg <= 1'b0;
         idx_reg       <= '0;
         ghr_lat_reg   <= '0;
         taken_reg     <= 1'b0;
         row_reg       <= '0;
         train_reg     <= 1'b0;
      end else begin
         case (state_reg)
            ST_INIT: begin
               // One row is cleared per cycle. The last row's write and the
               // rise of init_done happen on the same edge.
               if (init_cnt_reg == IDX_W'(TABLE_DEPTH - 1)) begin
                  state_reg     <= ST_IDLE;
                  init_done_reg <= 1'b1;
                  upd_ready_reg <= 1'b1;
               end else begin
                  init_cnt_reg <= init_cnt_reg + IDX_W'(1);
               end
            end
            ST_IDLE: begin
               if (upd_accept) begin
                  idx_reg       <= upd_pc[IDX_W+1:2];
                  ghr_lat_reg   <= upd_ghr;
                  taken_reg     <= upd_taken;
                  upd_ready_reg <= 1'b0;
                  state_reg     <= ST_CALC;
               end
            end
            ST_CALC: begin
               row_reg   <= table_mem[idx_reg];
               train_reg <= calc_train;
               state_reg <= ST_WRITE;
            end
            ST_WRITE: begin
               upd_ready_reg <= 1'b1;
               state_reg     <= ST_IDLE;
            end
            default: begin
               state_reg <= ST_INIT;
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Speculative GHR. Recovery at acceptance has priority over the shift for
   // the prediction made in the same cycle; that shift is dropped because it
   // was built on the wrong path.
   // --------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ghr_reg <= '0;
      end else if (upd_accept && upd_mispredict) begin
         ghr_reg <= {upd_ghr[HIST_LEN-2:0], upd_taken};
      end else if (pred_valid && init_done_reg) begin
         ghr_reg <= {ghr_reg[HIST_LEN-2:0], pred_taken};
      end
   end

endmodule

// File: tb/tb_perceptron_bp_table.sv
// -----------------------------------------------------------------------------
// tb_perceptron_bp_table
//
// Self-checking bench for perceptron_bp_table. A behavioural model of the
// weight table and GHR uses plain integer arithmetic and predicts every
// prediction and training result. A second instance with a huge THETA covers
// weight saturation.
// -----------------------------------------------------------------------------
module tb_perceptron_bp_table;

   localparam int PC_W  = 32;
   localparam int TD    = 16;
   localparam int HL    = 8;
   localparam int WW    = 8;
   localparam int THETA = 29;
   localparam int SUM_W = WW + $clog2(HL + 1) + 1;
   localparam int WMAX  = (1 << (WW - 1)) - 1;

   logic            clk;
   logic            rst_n;

   // main instance (default THETA)
   logic            pred_valid;
   logic [PC_W-1:0] pred_pc;
   logic            pred_taken;
   logic [SUM_W-1:0] pred_conf;
   logic [HL-1:0]   pred_ghr;
   logic            init_done;
   logic            upd_valid;
   logic            upd_ready;
   logic [PC_W-1:0] upd_pc;
   logic [HL-1:0]   upd_ghr;
   logic            upd_taken;
   logic            upd_mispredict;

   // saturation instance (THETA large enough that training never stops)
   logic            s_pred_valid;
   logic [PC_W-1:0] s_pred_pc;
   logic            s_pred_taken;
   logic [SUM_W-1:0] s_pred_conf;
   logic [HL-1:0]   s_pred_ghr;
   logic            s_init_done;
   logic            s_upd_valid;
   logic            s_upd_ready;
   logic [PC_W-1:0] s_upd_pc;
   logic [HL-1:0]   s_upd_ghr;
   logic            s_upd_taken;
   logic            s_upd_mispredict;

   int total;
   int bad;

   // behavioural model of the main instance
   int mw [TD][HL+1];
   int mghr;

   perceptron_bp_table #(
      .PC_W(PC_W), .TABLE_DEPTH(TD), .HIST_LEN(HL), .WEIGHT_W(WW), .THETA(THETA)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .pred_valid(pred_valid), .pred_pc(pred_pc), .pred_taken(pred_taken),
      .pred_conf(pred_conf), .pred_ghr(pred_ghr), .init_done(init_done),
      .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
      .upd_ghr(upd_ghr), .upd_taken(upd_taken), .upd_mispredict(upd_mispredict)
   );

   perceptron_bp_table #(
      .PC_W(PC_W), .TABLE_DEPTH(TD), .HIST_LEN(HL), .WEIGHT_W(WW), .THETA(100000)
   ) dut_sat (
      .clk(clk), .rst_n(rst_n),
      .pred_valid(s_pred_valid), .pred_pc(s_pred_pc), .pred_taken(s_pred_taken),
      .pred_conf(s_pred_conf), .pred_ghr(s_pred_ghr), .init_done(s_init_done),
      .upd_valid(s_upd_valid), .upd_ready(s_upd_ready), .upd_pc(s_upd_pc),
      .upd_ghr(s_upd_ghr), .upd_taken(s_upd_taken), .upd_mispredict(s_upd_mispredict)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------------------------------------------------------- model
   function automatic int m_idx(input logic [PC_W-1:0] pc);
      return int'(pc >> 2) % TD;
   endfunction

   function automatic int m_sum(input int row, input int g);
      int s;
      s = mw[row][0];
      for (int i = 1; i <= HL; i++) begin
         if (((g >> (i - 1)) & 1) == 1) s = s + mw[row][i];
         else                           s = s - mw[row][i];
      end
      return s;
   endfunction

   function automatic int m_clamp(input int v);
      if (v > WMAX)  return WMAX;
      if (v < -WMAX) return -WMAX;
      return v;
   endfunction

   function automatic void m_train(input int row, input int g, input bit tk);
      int s;
      int t;
      int x;
      int mag;
      s   = m_sum(row, g);
      t   = tk ? 1 : -1;
      mag = (s < 0) ? -s : s;
      if (((s >= 0) != tk) || (mag <= THETA)) begin
         mw[row][0] = m_clamp(mw[row][0] + t);
         for (int i = 1; i <= HL; i++) begin
            x = (((g >> (i - 1)) & 1) == 1) ? 1 : -1;
            mw[row][i] = m_clamp(mw[row][i] + t * x);
         end
      end
   endfunction

   function automatic void m_reset();
      for (int r = 0; r < TD; r++)
         for (int i = 0; i <= HL; i++)
            mw[r][i] = 0;
      mghr = 0;
   endfunction

   // ---------------------------------------------------------------- helpers
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Runs one full update on the main instance: accept, CALC, WRITE.
   // conf_w is pred_conf sampled during the WRITE cycle.
   task automatic do_update(input logic [PC_W-1:0] pc, input logic [HL-1:0] g,
                            input bit tk, input bit mp, output int conf_w);
      int waited;
      waited = 0;
      while (upd_ready !== 1'b1 && waited < 10) begin
         tick();
         waited++;
      end
      if (upd_ready !== 1'b1) begin
         total++; bad++;
         $display("FAIL upd_ready_timeout got=%b want=1", upd_ready);
      end
      upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = tk; upd_mispredict = mp;
      tick();
      upd_valid = 1'b0; upd_mispredict = 1'b0;
      if (mp) mghr = ((int'(g) << 1) | int'(tk)) & 255;
      tick();
      conf_w = int'($signed(pred_conf));
      tick();
      m_train(m_idx(pc), int'(g), tk);
      $display("upd pc=%h ghr=%h taken=%0d misp=%0d", pc, g, tk, mp);
   endtask

   // ---------------------------------------------------------------- tests
   task automatic test_reset();
      rst_n = 1'b0;
      pred_valid = 0; pred_pc = '0; upd_valid = 0; upd_pc = '0; upd_ghr = '0;
      upd_taken = 0; upd_mispredict = 0;
      s_pred_valid = 0; s_pred_pc = '0; s_upd_valid = 0; s_upd_pc = '0; s_upd_ghr = '0;
      s_upd_taken = 0; s_upd_mispredict = 0;
      repeat (3) tick();
      total++;
      if (upd_ready !== 1'b0 || init_done !== 1'b0 || pred_ghr !== 8'h00) begin
         bad++;
         $display("FAIL reset_hold got ready=%b done=%b ghr=%h want 0 0 00", upd_ready, init_done, pred_ghr);
      end
      rst_n = 1'b1;
      m_reset();
      for (int k = 0; k < TD; k++) begin
         pred_pc = $urandom;
         #1;
         total++;
         if (init_done !== 1'b0 || upd_ready !== 1'b0 || pred_taken !== 1'b0 || pred_conf !== '0) begin
            bad++;
            $display("FAIL init_sweep cyc=%0d got done=%b ready=%b taken=%b conf=%0d want 0 0 0 0",
                     k, init_done, upd_ready, pred_taken, $signed(pred_conf));
         end
         tick();
      end
      total++;
      if (init_done !== 1'b1 || upd_ready !== 1'b1) begin
         bad++;
         $display("FAIL init_done_rise got done=%b ready=%b want 1 1", init_done, upd_ready);
      end
      for (int k = 0; k < 4; k++) begin
         pred_pc = $urandom;
         tick();
         total++;
         if (pred_conf !== '0 || pred_taken !== 1'b1) begin
            bad++;
            $display("FAIL zero_table pc=%h got conf=%0d taken=%b want 0 1", pred_pc, $signed(pred_conf), pred_taken);
         end
      end
   endtask

   task automatic test_train_directed();
      int exp_seq [5];
      int cw;
      int prev;
      exp_seq = '{-9, -18, -27, -36, -36};
      pred_valid = 1'b0;
      pred_pc = 32'h0000_000C;
      for (int k = 0; k < 5; k++) begin
         prev = (k == 0) ? 0 : exp_seq[k-1];
         do_update(32'h0000_000C, 8'h00, 1'b0, 1'b0, cw);
         total++;
         if (cw !== prev) begin
            bad++;
            $display("FAIL write_cycle_old_value k=%0d got=%0d want=%0d", k, cw, prev);
         end
         total++;
         if (int'($signed(pred_conf)) !== exp_seq[k] || pred_taken !== 1'b0) begin
            bad++;
            $display("FAIL train_seq k=%0d got conf=%0d taken=%b want %0d 0",
                     k, $signed(pred_conf), pred_taken, exp_seq[k]);
         end
         total++;
         if (int'($signed(pred_conf)) !== m_sum(3, mghr)) begin
            bad++;
            $display("FAIL train_model k=%0d got=%0d want=%0d", k, $signed(pred_conf), m_sum(3, mghr));
         end
      end
   endtask

   task automatic test_ghr();
      // row 4 is all zero, so each prediction is taken
      pred_pc = 32'h0000_0010;
      pred_valid = 1'b1;
      repeat (3) tick();
      pred_valid = 1'b0;
      mghr = 7;
      total++;
      if (pred_ghr !== 8'b0000_0111) begin
         bad++;
         $display("FAIL ghr_shift got=%b want=00000111", pred_ghr);
      end
      total++;
      if (upd_ready !== 1'b1) begin
         bad++;
         $display("FAIL ghr_ready got=%b want=1", upd_ready);
      end
      pred_valid = 1'b1;
      upd_valid = 1'b1; upd_pc = 32'h0000_0014; upd_ghr = 8'h01; upd_taken = 1'b0; upd_mispredict = 1'b1;
      tick();
      pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0;
      mghr = 2;
      total++;
      if (pred_ghr !== 8'b0000_0010) begin
         bad++;
         $display("FAIL ghr_recover got=%b want=00000010", pred_ghr);
      end
      tick(); tick();
      m_train(5, 1, 1'b0);
      $display("upd pc=00000014 ghr=01 taken=0 misp=1 (with pred_valid)");
      pred_pc = 32'h0000_0014;
      #1;
      total++;
      if (int'($signed(pred_conf)) !== m_sum(5, mghr)) begin
         bad++;
         $display("FAIL ghr_row5 got=%0d want=%0d", $signed(pred_conf), m_sum(5, mghr));
      end
   endtask

   task automatic test_random();
      int op;
      int e;
      int cw;
      bit et;
      logic [PC_W-1:0] pc;
      for (int n = 0; n < 60; n++) begin
         op = $urandom_range(0, 2);
         pc = ($urandom & 32'hFFFF_FFC3) | (PC_W'($urandom_range(0, 3)) << 2);
         if (op == 0) begin
            pred_pc = pc;
            tick();
            e = m_sum(m_idx(pc), mghr);
            total++;
            if (int'($signed(pred_conf)) !== e || pred_taken !== (e >= 0) || int'(pred_ghr) !== mghr) begin
               bad++;
               $display("FAIL rnd_pred pc=%h got conf=%0d taken=%b ghr=%h want %0d %b %h",
                        pc, $signed(pred_conf), pred_taken, pred_ghr, e, (e >= 0), mghr);
            end
         end else if (op == 1) begin
            pred_pc = pc;
            pred_valid = 1'b1;
            #1;
            et = (m_sum(m_idx(pc), mghr) >= 0);
            total++;
            if (pred_taken !== et) begin
               bad++;
               $display("FAIL rnd_shift_taken pc=%h got=%b want=%b", pc, pred_taken, et);
            end
            tick();
            pred_valid = 1'b0;
            mghr = ((mghr << 1) | int'(et)) & 255;
            total++;
            if (int'(pred_ghr) !== mghr) begin
               bad++;
               $display("FAIL rnd_shift_ghr got=%h want=%h", pred_ghr, mghr);
            end
         end else begin
            pred_pc = pc;
            do_update(pc, 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                      ($urandom_range(0, 3) == 0), cw);
            #1;
            e = m_sum(m_idx(pc), mghr);
            total++;
            if (int'($signed(pred_conf)) !== e || int'(pred_ghr) !== mghr) begin
               bad++;
               $display("FAIL rnd_update pc=%h got conf=%0d ghr=%h want %0d %h",
                        pc, $signed(pred_conf), pred_ghr, e, mghr);
            end
         end
      end
   endtask

   task automatic test_back_to_back();
      logic [PC_W-1:0] pc;
      logic [HL-1:0]   g;
      bit              tk;
      bit              exp_rdy;
      int              e;
      pc = 32'h0000_0018;
      g  = 8'($urandom_range(0, 255));
      tk = 1'($urandom_range(0, 1));
      pred_pc = pc;
      upd_valid = 1'b1; upd_pc = pc; upd_ghr = g; upd_taken = tk; upd_mispredict = 1'b0;
      for (int i = 0; i < 9; i++) begin
         exp_rdy = ((i % 3) == 0);
         total++;
         if (upd_ready !== exp_rdy) begin
            bad++;
            $display("FAIL b2b_ready cyc=%0d got=%b want=%b", i, upd_ready, exp_rdy);
         end
         if (exp_rdy) begin
            m_train(m_idx(pc), int'(g), tk);
            $display("upd pc=%h ghr=%h taken=%0d misp=0 (held valid, cyc %0d)", pc, g, tk, i);
         end
         tick();
      end
      upd_valid = 1'b0;
      #1;
      e = m_sum(m_idx(pc), mghr);
      total++;
      if (int'($signed(pred_conf)) !== e) begin
         bad++;
         $display("FAIL b2b_result got=%0d want=%0d", $signed(pred_conf), e);
      end
   endtask

   task automatic test_saturation();
      s_pred_pc = '0;
      s_pred_valid = 1'b1;
      repeat (8) tick();
      s_pred_valid = 1'b0;
      total++;
      if (s_pred_ghr !== 8'hFF) begin
         bad++;
         $display("FAIL sat_ghr got=%h want=ff", s_pred_ghr);
      end
      s_upd_valid = 1'b1; s_upd_pc = '0; s_upd_ghr = 8'hFF; s_upd_taken = 1'b1; s_upd_mispredict = 1'b0;
      for (int i = 0; i < 390; i++) begin
         if (i == 192) begin
            total++;
            if (int'($signed(s_pred_conf)) !== 576) begin
               bad++;
               $display("FAIL sat_mid got=%0d want=576", $signed(s_pred_conf));
            end
         end
         tick();
      end
      s_upd_valid = 1'b0;
      #1;
      total++;
      if (int'($signed(s_pred_conf)) !== 9 * WMAX || s_pred_taken !== 1'b1) begin
         bad++;
         $display("FAIL sat_final got conf=%0d taken=%b want %0d 1", $signed(s_pred_conf), s_pred_taken, 9 * WMAX);
      end
      $display("sat 130 taken updates to row 0, conf=%0d", $signed(s_pred_conf));
   endtask

   task automatic test_reset_mid_write();
      pred_pc = 32'h0000_0014;
      total++;
      if (upd_ready !== 1'b1) begin
         bad++;
         $display("FAIL rmw_ready got=%b want=1", upd_ready);
      end
      upd_valid = 1'b1; upd_pc = 32'h0000_0014; upd_ghr = 8'($urandom_range(0, 255));
      upd_taken = 1'b1; upd_mispredict = 1'b0;
      tick();
      upd_valid = 1'b0;
      tick();
      rst_n = 1'b0;
      #1;
      total++;
      if (upd_ready !== 1'b0 || init_done !== 1'b0 || pred_conf !== '0 || pred_ghr !== 8'h00) begin
         bad++;
         $display("FAIL rmw_async got ready=%b done=%b conf=%0d ghr=%h want 0 0 0 00",
                  upd_ready, init_done, $signed(pred_conf), pred_ghr);
      end
      tick(); tick();
      rst_n = 1'b1;
      m_reset();
      for (int k = 0; k < TD; k++) begin
         total++;
         if (init_done !== 1'b0) begin
            bad++;
            $display("FAIL rmw_init cyc=%0d got=%b want=0", k, init_done);
         end
         tick();
      end
      total++;
      if (init_done !== 1'b1 || pred_conf !== '0 || pred_taken !== 1'b1) begin
         bad++;
         $display("FAIL rmw_row5 got done=%b conf=%0d taken=%b want 1 0 1",
                  init_done, $signed(pred_conf), pred_taken);
      end
   endtask

   initial begin
      total = 0;
      bad   = 0;
      test_reset();
      test_train_directed();
      test_ghr();
      test_random();
      test_back_to_back();
      test_saturation();
      test_reset_mid_write();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/perceptron_bp_table.md
Name: perceptron_bp_table

Overview:
Parametrised global-history perceptron branch predictor, successor to the single-perceptron fixed-feature predictor. It holds a table of perceptron rows indexed by PC bits and a speculative global history register (GHR) that recovers on mispredict. Training is two-stage and threshold-based. It sits beside the IF stage: prediction is combinational from pred_pc, and training and recovery come from EX branch resolution.

Parameters:
PC_W, 32, PC width
TABLE_DEPTH, 16, number of perceptron rows (power of 2, >=2); IDX_W = clog2(TABLE_DEPTH)
HIST_LEN, 8, GHR length = weights per row excluding bias (>=2)
WEIGHT_W, 8, signed weight width; saturating range [-(2^(WEIGHT_W-1)-1), +(2^(WEIGHT_W-1)-1)]
THETA, 29, training threshold on |sum| (non-negative)
SUM_W (localparam), WEIGHT_W + clog2(HIST_LEN+1) + 1, signed sum width

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
pred_valid  in  1  IF has a branch this cycle; shift prediction into GHR
pred_pc  in  PC_W  PC to predict
pred_taken  out  1  prediction (combinational)
pred_conf  out  SUM_W  signed perceptron sum (combinational)
pred_ghr  out  HIST_LEN  GHR value used for this prediction, carried down the pipe
init_done  out  1  table sweep complete
upd_valid  in  1  resolved branch presented
upd_ready  out  1  update accepted when upd_valid & upd_ready
upd_pc  in  PC_W  PC of resolved branch
upd_ghr  in  HIST_LEN  pred_ghr snapshot from prediction time
upd_taken  in  1  actual outcome
upd_mispredict  in  1  EX detected mispredict; restore GHR

Behaviour:
- Row r: bias w0 and w1..wHIST_LEN. Index = pc[IDX_W+1:2].
- Inputs: x_i = +1 if ghr[i-1] else -1. sum = w0 + sum over i of (x_i ? w_i : -w_i), sign-extended to SUM_W with no overflow.
- Prediction: pred_taken = (sum >= 0); pred_conf = sum; pred_ghr = current GHR. While !init_done: pred_taken=0, pred_conf=0.
- GHR: on pred_valid & init_done at clk edge, ghr <= {ghr[HIST_LEN-2:0], pred_taken}.
- GHR recovery: on accepted update with upd_mispredict, ghr <= {upd_ghr[HIST_LEN-2:0], upd_taken}. Recovery wins over a same-cycle pred_valid shift.
- FSM states INIT, IDLE, CALC, WRITE.
  - INIT: counter 0..TABLE_DEPTH-1 writes an all-zero row per cycle. After the last row -> IDLE and init_done=1, so init takes TABLE_DEPTH cycles.
  - IDLE: upd_ready=1. Acceptance latches pc index, upd_ghr, upd_taken -> CALC.
  - CALC: upd_ready=0. Register the row read, sum with latched ghr, and train = (sum>=0)!=taken | |sum|<=THETA -> WRITE.
  - WRITE: upd_ready=0. If train: w0 += t, w_i += t*x_i (t=+1 taken, -1 not), each clamped at ±(2^(WEIGHT_W-1)-1). Row written at the edge leaving WRITE -> IDLE.
  - Throughput: one update per 3 cycles.
- Same-cycle prediction to the row being written reads the old value; the new value is visible the next cycle.
- GHR recovery happens at acceptance, not at WRITE.
- Reset values: ghr=0, state=INIT, init counter=0, init_done=0, upd_ready=0, latched regs=0. Table contents are undefined until the INIT sweep ends.
- Reset asserted mid-CALC or mid-WRITE aborts the pending write with no partial row update. The FSM restarts INIT.
- upd_valid is ignored while upd_ready=0. The source must hold inputs until accepted.

Test Plan:
- Reset deasserted -> upd_ready=0, init_done=0, pred_taken=0 for exactly 16 cycles. Then init_done=1, and any pc gives pred_conf=0, pred_taken=1.
- Four updates to pc=0x0C (row 3), upd_ghr=0, taken=0, no mispredict -> pred_conf for 0x0C goes -9, -18, -27, -36, with w0=-4 and w_i=+4. A 5th update leaves it at -36 because it is correct and |sum|>29.
- THETA=100000, WEIGHT_W=8: 130 taken updates with upd_ghr=all-ones to one row -> w0=+127, all w_i=+127, pred_conf=+1143, no wrap.
- pred_valid for 3 cycles with pred_taken=1 -> ghr=0b00000111. Then an accepted upd_mispredict with upd_ghr=0b00000001, upd_taken=0 in the same cycle as pred_valid -> ghr=0b00000010, and the shift is dropped.
- upd_valid held high continuously -> acceptances at cycles N, N+3, N+6, and upd_ready=0 during CALC/WRITE.
- rst_n low during WRITE of row 5 -> after re-init, row 5 predicts pred_conf=0, and init_done rises 16 cycles after rst_n release.
